timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Bus-mapped controller that sequences a 32-bit wrap-around counter: prescaler, period compare, enable, one-shot/periodic mode, sticky overflow status and interrupt. It sits on the native valid/ready memory bus as a peripheral slave. It drives cnt/overflow-style outputs to downstream logic (PWM, LED blinkers, CPU IRQ line).

Parameters:
PRESCALE_W, 16, width of prescaler register and prescaler counter (1..32)
RESET_PERIOD, 32'hFFFF_FFFF, PERIOD register value after reset

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
valid  input  1  bus request; held by master until ready
ready  output  1  bus acknowledge, one-cycle pulse
wstrb  input  4  byte write strobes; 0 = read
addr  input  32  byte address; only addr[4:2] decoded
wdata  input  32  write data
rdata  output  32  read data, valid while ready=1
cnt  output  32  current count
tick  output  1  one-cycle pulse on each period wrap
irq  output  1  level interrupt = STS.OVF & CTRL.IRQ_EN

Behaviour:
- Reset (async, resetn=0): ready=0, rdata=0, cnt=0, tick=0, irq=0, CTRL=0, PERIOD=RESET_PERIOD, PRESCALE=0, prescaler=0, OVF=0, state=IDLE.
- Bus handshake: ready <= valid & ~ready, so one wait state and a single-cycle pulse. Back-to-back accesses are separated by at least one ready-low cycle.
- Register writes commit on the edge that raises ready. rdata is loaded on that same edge.
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN. Byte0 strobe only; other bits read 0.
  - 1 PERIOD: R/W, per-byte strobes.
  - 2 PRESCALE: R/W, PRESCALE_W bits, per-byte strobes; upper bits read 0.
  - 3 COUNT: read-only, returns cnt; writes ignored.
  - 4 STATUS: bit0 OVF sticky, write-1-to-clear; bit1 RUNNING read-only.
  - 5..7: read 0, writes ignored.
- States: IDLE, RUN, DONE. RUNNING = (state==RUN).
  - IDLE: cnt holds its value. A CTRL write with EN 0->1 clears cnt and prescaler, then -> RUN.
  - RUN: prescaler increments each cycle. When prescaler==PRESCALE: prescaler<=0 and an internal step occurs.
    - On step with cnt>=PERIOD: cnt<=0, tick=1 for one cycle, OVF<=1. If ONESHOT: EN<=0, -> DONE.
    - On step otherwise: cnt<=cnt+1.
  - RUN with a CTRL write of EN=0: -> IDLE next edge; cnt and prescaler freeze.
  - DONE: cnt=0, EN reads 0. A write of EN=1 -> RUN from cnt=0, prescaler=0.
- Period in clocks = (PRESCALE+1)*(PERIOD+1). PRESCALE=0 steps every cycle; PERIOD=0 ticks every step.
- PERIOD written mid-run takes effect on the next compare. If cnt already exceeds the new PERIOD, the next step wraps (>= compare); it never runs to 2^32.
- Writing EN=1 while already in RUN is a no-op: no restart, cnt keeps counting.
- Changing ONESHOT mid-run takes effect at the next wrap.
- A wrap that sets OVF and a W1C clear of OVF on the same edge: set wins, OVF=1.
- Arithmetic is unsigned. cnt+1 never overflows because the compare bounds it.
- tick and irq are registered outputs, with no combinational path from bus inputs.
- resetn asserted mid-transaction or mid-count: everything returns to reset values immediately. No ready is issued for the aborted access.

Test Plan:
- Reset then read all registers -> CTRL=0, PERIOD=32'hFFFF_FFFF, PRESCALE=0, COUNT=0, STATUS=0. Each access has ready high for exactly 1 cycle, 1 cycle after valid.
- PERIOD=3, PRESCALE=0, CTRL=1 -> cnt sequence 0,1,2,3,0,…; tick pulses every 4 clocks; STATUS.OVF=1 after the first wrap.
- PERIOD=2, PRESCALE=4, CTRL=3 (oneshot) -> exactly one tick 15 clocks after enable. Then STATUS=1 (RUNNING=0), CTRL reads 2, cnt stays 0.
- CTRL=5, run until OVF -> irq=1. Write STATUS=1 -> irq=0 on the next edge. Repeat with the clear landing on the wrap edge -> OVF stays 1.
- Running with cnt=10, PERIOD=100: write PERIOD=5 -> wrap on the next step. Byte write of PERIOD with wstrb=4'b0010, wdata=32'h0000_AB00 changes only bits 15:8.
- Assert resetn low mid-count with cnt=7 and a pending valid -> cnt=0 and ready=0 immediately. After release the counter is IDLE until EN is written.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-mapped 32-bit prescaled period timer with one-shot/periodic modes, sticky OVF and level IRQ.
// Latency: bus ready one cycle after valid; register writes and rdata land on that edge; tick/irq are registered.
// Backpressure: master holds valid until the single-cycle ready pulse; accesses are separated by a ready-low cycle.
module timer_ctrl #(
  parameter int unsigned PRESCALE_W   = 16,
  parameter logic [31:0] RESET_PERIOD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] cnt,
  output logic        tick,
  output logic        irq
);

  // Register indices as seen on addr[4:2].
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  ctrl_en;
  logic                  ctrl_oneshot;
  logic                  ctrl_irq_en;
  logic [31:0]           period;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  ovf;

  logic [2:0]            reg_sel;
  logic                  acc;
  logic                  wr_any;
  logic                  wr_ctrl;
  logic                  wr_period;
  logic                  wr_prescale;
  logic                  wr_status;
  logic                  en_set;
  logic                  en_clr;
  logic                  ovf_clr;
  logic                  step;
  logic                  wrap;
  logic                  ovf_nxt;
  logic                  irq_en_nxt;
  logic [31:0]           period_nxt;
  logic [PRESCALE_W-1:0] prescale_nxt;
  logic [31:0]           rd_mux;

  // Only addr[4:2] selects a register; the rest of the address is don't-care.
  logic unused_addr_ok;
  assign unused_addr_ok = ^{addr[31:5], addr[1:0]};

  // Bus decode: an access is accepted on the edge that raises ready.
  always_comb begin
    reg_sel     = addr[4:2];
    acc         = valid & ~ready;
    wr_any      = acc & (|wstrb);
    wr_ctrl     = wr_any & (reg_sel == REG_CTRL) & wstrb[0];
    wr_period   = wr_any & (reg_sel == REG_PERIOD);
    wr_prescale = wr_any & (reg_sel == REG_PRESCALE);
    wr_status   = wr_any & (reg_sel == REG_STATUS) & wstrb[0];
    en_set      = wr_ctrl & wdata[0];
    en_clr      = wr_ctrl & ~wdata[0];
    ovf_clr     = wr_status & wdata[0];
  end

  // Count engine decode: a stop request pre-empts the step on the same edge.
  always_comb begin
    step = (state == RUN) & ~en_clr & (presc_cnt == prescale);
    wrap = step & (cnt >= period);
  end

  // Read mux reflects register contents before any write on the same edge.
  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      REG_CTRL:     rd_mux[2:0] = {ctrl_irq_en, ctrl_oneshot, ctrl_en};
      REG_PERIOD:   rd_mux = period;
      REG_PRESCALE: begin
        for (int i = 0; i < int'(PRESCALE_W); i++) begin
          rd_mux[i] = prescale[i];
        end
      end
      REG_COUNT:    rd_mux = cnt;
      REG_STATUS:   rd_mux[1:0] = {(state == RUN), ovf};
      default:      rd_mux = '0;
    endcase
  end

  // Next values of software-visible fields; a wrap beats a same-edge OVF clear.
  always_comb begin
    period_nxt   = period;
    prescale_nxt = prescale;
    if (wr_period) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) period_nxt[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (wr_prescale) begin
      for (int i = 0; i < int'(PRESCALE_W); i++) begin
        if (wstrb[i/8]) prescale_nxt[i] = wdata[i];
      end
    end
    irq_en_nxt = wr_ctrl ? wdata[2] : ctrl_irq_en;
    ovf_nxt    = wrap | (ovf & ~ovf_clr);
  end

  // Bus handshake: one wait state, single-cycle ready, rdata captured with ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= acc;
      rdata <= acc ? rd_mux : '0;
    end
  end

  // Configuration registers written from the bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period       <= RESET_PERIOD;
      prescale     <= '0;
      ctrl_oneshot <= 1'b0;
      ctrl_irq_en  <= 1'b0;
    end else begin
      period      <= period_nxt;
      prescale    <= prescale_nxt;
      ctrl_irq_en <= irq_en_nxt;
      if (wr_ctrl) ctrl_oneshot <= wdata[1];
    end
  end

  // Timer FSM: owns EN, the counters, sticky OVF and the registered tick/irq outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      cnt       <= '0;
      presc_cnt <= '0;
      ovf       <= 1'b0;
      tick      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      tick <= wrap;
      ovf  <= ovf_nxt;
      irq  <= ovf_nxt & irq_en_nxt;
      case (state)
        IDLE, DONE: begin
          // Starting always begins a fresh period; EN=0 writes here change nothing.
          if (en_set) begin
            state     <= RUN;
            ctrl_en   <= 1'b1;
            cnt       <= '0;
            presc_cnt <= '0;
          end
        end
        RUN: begin
          if (en_clr) begin
            // Counters freeze where they are so software can read them back.
            state   <= IDLE;
            ctrl_en <= 1'b0;
          end else if (step) begin
            presc_cnt <= '0;
            if (wrap) begin
              cnt <= '0;
              if (ctrl_oneshot) begin
                state   <= DONE;
                ctrl_en <= 1'b0;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ctrl_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized bus traffic for timer_ctrl.
// Outputs are compared every cycle against a behavioural model of the register/timer rules.
// Directed scenarios also pin hand-computed values (latency, tick timing, read-back contents).
module tb_timer_ctrl;

  localparam int          PW    = 16;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;  // PW bits of prescaler
  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [31:0] cnt;
  logic        tick;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  int last_lat = 0;

  timer_ctrl #(.PRESCALE_W(PW), .RESET_PERIOD(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .cnt(cnt), .tick(tick), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ready, m_tick, m_irq, m_ovf, m_one, m_ien;
  logic [31:0] m_rdata, m_cnt, m_period, m_psc, m_div;
  int          m_mode;

  task automatic model_edge();
    logic        acc, w, ctl, wrapped;
    logic [2:0]  sel;
    logic [31:0] rv;
    acc = valid && !m_ready;
    w   = acc && (wstrb != 4'h0);
    sel = addr[4:2];
    ctl = w && (sel == 3'd0) && wstrb[0];
    case (sel)
      3'd0: rv = {29'd0, m_ien, m_one, (m_mode == M_RUN)};
      3'd1: rv = m_period;
      3'd2: rv = m_psc;
      3'd3: rv = m_cnt;
      3'd4: rv = {30'd0, (m_mode == M_RUN), m_ovf};
      default: rv = 32'd0;
    endcase
    wrapped = 1'b0;
    if (m_mode == M_RUN) begin
      if (ctl && !wdata[0]) m_mode = M_STOP;
      else if (m_div == m_psc) begin
        m_div = 0;
        if (m_cnt >= m_period) begin
          wrapped = 1'b1;
          m_cnt = 0;
          if (m_one) m_mode = M_DONE;
        end else m_cnt = m_cnt + 1;
      end else m_div = (m_div + 1) & PMASK;
    end else if (ctl && wdata[0]) begin
      m_mode = M_RUN;
      m_cnt = 0;
      m_div = 0;
    end
    if (ctl) begin
      m_one = wdata[1];
      m_ien = wdata[2];
    end
    for (int b = 0; b < 4; b++) begin
      if (w && sel == 3'd1 && wstrb[b]) m_period[8*b +: 8] = wdata[8*b +: 8];
      if (w && sel == 3'd2 && wstrb[b]) m_psc[8*b +: 8] = wdata[8*b +: 8];
    end
    m_psc   = m_psc & PMASK;
    m_ovf   = wrapped || (m_ovf && !(w && sel == 3'd4 && wstrb[0] && wdata[0]));
    m_tick  = wrapped;
    m_irq   = m_ovf && m_ien;
    m_rdata = acc ? rv : 32'd0;
    m_ready = acc;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready = 0; m_rdata = 0; m_cnt = 0; m_period = 32'hFFFF_FFFF; m_psc = 0; m_div = 0;
      m_mode = M_STOP; m_one = 0; m_ien = 0; m_ovf = 0; m_tick = 0; m_irq = 0;
    end else begin
      model_edge();
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("cnt", cnt, m_cnt);
      chk("tick", 32'(tick), 32'(m_tick));
      chk("irq", 32'(irq), 32'(m_irq));
      if (m_ready) chk("rdata", rdata, m_rdata);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic [2:0] sel, input logic [3:0] strb, input logic [31:0] d,
                     output logic [31:0] rd);
    logic [31:0] a;
    int waited;
    @(negedge clk);
    a = $urandom;
    a[4:2] = sel;
    addr = a; wstrb = strb; wdata = d; valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready && waited < 8);
    chk("bus_ready_seen", 32'(ready), 32'd1);
    last_lat = waited;
    rd = rdata;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d);
    logic [31:0] dummy;
    bus(sel, 4'hF, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] sel, input logic [31:0] exp);
    logic [31:0] v;
    bus(sel, 4'h0, 32'h0, v);
    chk(name, v, exp);
  endtask

  task automatic wait_cnt(input logic [31:0] v, input int limit);
    int k = 0;
    while (cnt !== v && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cnt", cnt, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_at, ticks;
    logic [2:0]  sel;
    logic [3:0]  strb;
    logic [31:0] d, v;

    #22 resetn = 1'b1;

    // Reset values and handshake latency.
    rd_chk("rst_ctrl", 3'd0, 32'h0);
    chk("ready_latency", 32'(last_lat), 32'd1);
    rd_chk("rst_period", 3'd1, 32'hFFFF_FFFF);
    rd_chk("rst_prescale", 3'd2, 32'h0);
    rd_chk("rst_count", 3'd3, 32'h0);
    rd_chk("rst_status", 3'd4, 32'h0);
    chk("ready_latency2", 32'(last_lat), 32'd1);

    // Periodic, PERIOD=3, PRESCALE=0: 0,1,2,3,0,... tick every 4 clocks.
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd0);
    wr(3'd0, 32'd1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      chk("seq_cnt", cnt, 32'(k % 4));
      chk("seq_tick", 32'(tick), 32'((k > 0) && (k % 4 == 0)));
    end
    rd_chk("seq_status", 3'd4, 32'h3);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // One-shot, PERIOD=2, PRESCALE=4: single tick 15 clocks after enable.
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd4);
    wr(3'd0, 32'd3);
    first_at = -1; ticks = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (tick) begin
        ticks++;
        if (first_at < 0) first_at = k;
      end
    end
    chk("oneshot_tick_at", 32'(first_at), 32'd15);
    chk("oneshot_ticks", 32'(ticks), 32'd1);
    rd_chk("oneshot_status", 3'd4, 32'h1);
    rd_chk("oneshot_ctrl", 3'd0, 32'h2);
    rd_chk("oneshot_count", 3'd3, 32'h0);

    // IRQ: set, clear, then clear landing on the wrap edge.
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd0, 32'd5);
    begin
      int k = 0;
      while (!irq && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    chk("irq_rise", 32'(irq), 32'd1);
    wait_cnt(32'd0, 8);
    wr(3'd4, 32'd1);
    chk("irq_cleared", 32'(irq), 32'd0);
    chk("irq_clear_cnt", cnt, 32'd2);
    wr(3'd4, 32'd1);
    chk("irq_set_wins", 32'(irq), 32'd1);
    chk("irq_wrap_tick", 32'(tick), 32'd1);
    rd_chk("irq_status", 3'd4, 32'h3);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // PERIOD lowered below cnt mid-run wraps on the next step; byte-lane write.
    wr(3'd1, 32'd100);
    wr(3'd0, 32'd1);
    wait_cnt(32'd10, 200);
    wr(3'd1, 32'd5);
    chk("shrink_cnt", cnt, 32'd12);
    @(negedge clk);
    chk("shrink_wrap_cnt", cnt, 32'd0);
    chk("shrink_wrap_tick", 32'(tick), 32'd1);
    bus(3'd1, 4'b0010, 32'h0000_AB00, v);
    rd_chk("byte_period", 3'd1, 32'h0000_AB05);
    wr(3'd0, 32'd0);

    // Asynchronous reset mid-count with a pending access.
    wr(3'd1, 32'd1000);
    wr(3'd0, 32'd1);
    wait_cnt(32'd7, 50);
    addr = 32'h0; wstrb = 4'h0; valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    chk("arst_ready_hold", 32'(ready), 32'd0);
    valid = 1'b0;
    #2 resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", cnt, 32'd0);
    rd_chk("post_rst_ctrl", 3'd0, 32'h0);
    rd_chk("post_rst_status", 3'd4, 32'h0);

    // Randomized traffic against the model.
    for (int cfg = 0; cfg < 4; cfg++) begin
      wr(3'd0, 32'd0);
      wr(3'd2, 32'($urandom_range(0, 2)));
      wr(3'd1, 32'($urandom_range(0, 6)));
      wr(3'd0, 32'd1 | ($urandom & 32'd6));
      for (int n = 0; n < 80; n++) begin
        sel  = 3'($urandom_range(0, 7));
        strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        if (sel == 3'd2) strb = 4'h0;
        case (sel)
          3'd0: d = 32'($urandom_range(0, 7));
          3'd1: d = 32'($urandom_range(0, 9));
          default: d = $urandom;
        endcase
        bus(sel, strb, d, v);
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
